// File: rtl/sync_dpram_param_if.sv
// Port bundle for sync_dpram_param: write port, read port and status outputs.
// With SYNC_DPRAM_PARITY_EN defined the bundle also carries err_inject and rd_perr.
interface sync_dpram_param_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) ();
   logic              we;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] din;
   logic              re;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] dout;
   logic              rd_valid;
   logic              init_busy;
`ifdef SYNC_DPRAM_PARITY_EN
   logic              err_inject;
   logic              rd_perr;

   modport master (
      output we, wr_addr, din, re, rd_addr, err_inject,
      input  dout, rd_valid, init_busy, rd_perr
   );
   modport slave (
      input  we, wr_addr, din, re, rd_addr, err_inject,
      output dout, rd_valid, init_busy, rd_perr
   );
`else
   modport master (
      output we, wr_addr, din, re, rd_addr,
      input  dout, rd_valid, init_busy
   );
   modport slave (
      input  we, wr_addr, din, re, rd_addr,
      output dout, rd_valid, init_busy
   );
`endif
endinterface

// File: rtl/sync_dpram_param.sv
// Simple dual-port synchronous RAM with post-reset clear sequencer, selectable
// collision mode and optional output register. Macro SYNC_DPRAM_PARITY_EN adds parity.
module sync_dpram_param #(
   parameter int DATA_W  = 8,
   parameter int ADDR_W  = 4,
   parameter int RD_MODE = 0,
   parameter int OUT_REG = 0
) (
   input logic               clk,
   input logic               rst,
   sync_dpram_param_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic {CLEAR, READY} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic              init_busy_q, init_busy_d;

   logic [DATA_W-1:0] mem [DEPTH];
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic              rd_accept;
   logic [DATA_W-1:0] rd_word;

   logic [DATA_W-1:0] dout_p1_q, dout_p1_d;
   logic              vld_p1_q, vld_p1_d;

`ifdef SYNC_DPRAM_PARITY_EN
   logic              par_mem [DEPTH];
   logic              mem_wpar;
   logic              rd_par;
   logic              perr_p1_q, perr_p1_d;
`endif

   function automatic logic even_par(input logic [DATA_W-1:0] d);
      return ^d;
   endfunction

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      mem_we    = 1'b0;
      mem_waddr = bus.wr_addr;
      mem_wdata = bus.din;
      rd_accept = 1'b0;
`ifdef SYNC_DPRAM_PARITY_EN
      mem_wpar  = even_par(bus.din) ^ bus.err_inject;
`endif
      case (state_q)
         CLEAR: begin
            // The sequencer owns the write port; user we/re are dropped.
            mem_we    = 1'b1;
            mem_waddr = clr_cnt_q;
            mem_wdata = '0;
`ifdef SYNC_DPRAM_PARITY_EN
            mem_wpar  = 1'b0;
`endif
            clr_cnt_d = clr_cnt_q + ADDR_W'(1);
            if (clr_cnt_q == ADDR_W'(DEPTH - 1)) state_d = READY;
         end
         READY: begin
            mem_we    = bus.we;
            rd_accept = bus.re;
         end
         default: state_d = CLEAR;
      endcase
      init_busy_d = (state_d == CLEAR);
   end

   always_comb begin
      rd_word = mem[bus.rd_addr];
`ifdef SYNC_DPRAM_PARITY_EN
      rd_par  = par_mem[bus.rd_addr];
`endif
      // Write-first bypass: a same-address read sees the word being written.
      if (RD_MODE == 1 && bus.we && (bus.wr_addr == bus.rd_addr)) begin
         rd_word = bus.din;
`ifdef SYNC_DPRAM_PARITY_EN
         rd_par  = mem_wpar;
`endif
      end
      dout_p1_d = rd_accept ? rd_word : dout_p1_q;
      vld_p1_d  = rd_accept;
`ifdef SYNC_DPRAM_PARITY_EN
      perr_p1_d = rd_accept && (even_par(rd_word) != rd_par);
`endif
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
`ifdef SYNC_DPRAM_PARITY_EN
         par_mem[mem_waddr] <= mem_wpar;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= CLEAR;
         clr_cnt_q   <= '0;
         init_busy_q <= 1'b1;
         dout_p1_q   <= '0;
         vld_p1_q    <= 1'b0;
`ifdef SYNC_DPRAM_PARITY_EN
         perr_p1_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         clr_cnt_q   <= clr_cnt_d;
         init_busy_q <= init_busy_d;
         dout_p1_q   <= dout_p1_d;
         vld_p1_q    <= vld_p1_d;
`ifdef SYNC_DPRAM_PARITY_EN
         perr_p1_q   <= perr_p1_d;
`endif
      end
   end

   assign bus.init_busy = init_busy_q;

   // ---- stage p1 -> p2 (optional output register) ----
   if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] dout_p2_q, dout_p2_d;
      logic              vld_p2_q, vld_p2_d;
`ifdef SYNC_DPRAM_PARITY_EN
      logic              perr_p2_q, perr_p2_d;
`endif

      always_comb begin
         dout_p2_d = vld_p1_q ? dout_p1_q : dout_p2_q;
         vld_p2_d  = vld_p1_q;
`ifdef SYNC_DPRAM_PARITY_EN
         perr_p2_d = perr_p1_q;
`endif
      end

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            dout_p2_q <= '0;
            vld_p2_q  <= 1'b0;
`ifdef SYNC_DPRAM_PARITY_EN
            perr_p2_q <= 1'b0;
`endif
         end else begin
            dout_p2_q <= dout_p2_d;
            vld_p2_q  <= vld_p2_d;
`ifdef SYNC_DPRAM_PARITY_EN
            perr_p2_q <= perr_p2_d;
`endif
         end
      end

      assign bus.dout     = dout_p2_q;
      assign bus.rd_valid = vld_p2_q;
`ifdef SYNC_DPRAM_PARITY_EN
      assign bus.rd_perr  = perr_p2_q;
`endif
   end else begin : g_no_out_reg
      assign bus.dout     = dout_p1_q;
      assign bus.rd_valid = vld_p1_q;
`ifdef SYNC_DPRAM_PARITY_EN
      assign bus.rd_perr  = perr_p1_q;
`endif
   end
endmodule

// File: tb/tb_sync_dpram_param.sv
// Bench for sync_dpram_param: DUT a (read-first, latency 1) and DUT b (write-first,
// latency 2) share stimulus and are checked against an array/queue reference model.
module tb_sync_dpram_param;
   localparam int DATA_W = 8;
   localparam int ADDR_W = 4;
   localparam int DEPTH  = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic we = 1'b0, re = 1'b0, err = 1'b0;
   logic [ADDR_W-1:0] wa = '0, ra = '0;
   logic [DATA_W-1:0] din = '0;

   int n_run = 0;
   int n_fail = 0;

   sync_dpram_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) if_a ();
   sync_dpram_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) if_b ();

   assign if_a.we = we;  assign if_a.wr_addr = wa;  assign if_a.din = din;
   assign if_a.re = re;  assign if_a.rd_addr = ra;
   assign if_b.we = we;  assign if_b.wr_addr = wa;  assign if_b.din = din;
   assign if_b.re = re;  assign if_b.rd_addr = ra;
`ifdef SYNC_DPRAM_PARITY_EN
   assign if_a.err_inject = err;
   assign if_b.err_inject = err;
`endif

   sync_dpram_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_MODE(0), .OUT_REG(0))
      dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
   sync_dpram_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_MODE(1), .OUT_REG(1))
      dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

   always #5 clk = ~clk;

   // Reference model state
   logic [DATA_W-1:0] m_mem [DEPTH];
   logic              m_par [DEPTH];
   int                clear_left;
   logic [DATA_W-1:0] ea_dout, eb_dout, pend_dat;
   logic              ea_vld, eb_vld, pend_vld, e_busy;
   logic              ea_perr, eb_perr, pend_perr;

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         m_mem[i] = '0;
         m_par[i] = 1'b0;
      end
      clear_left = DEPTH;
      ea_dout = '0; ea_vld = 1'b0; ea_perr = 1'b0;
      eb_dout = '0; eb_vld = 1'b0; eb_perr = 1'b0;
      pend_dat = '0; pend_vld = 1'b0; pend_perr = 1'b0;
      e_busy = 1'b1;
   endtask

   task automatic model_step();
      logic [DATA_W-1:0] old_d, b_d;
      logic              old_p, b_p;
      eb_vld  = pend_vld;
      if (pend_vld) eb_dout = pend_dat;
      eb_perr = pend_perr;
      if (clear_left > 0) begin
         clear_left--;
         ea_vld = 1'b0; ea_perr = 1'b0;
         pend_vld = 1'b0; pend_perr = 1'b0;
      end else begin
         old_d = m_mem[ra];
         old_p = m_par[ra];
         if (we && wa == ra) begin
            b_d = din; b_p = (^din) ^ err;
         end else begin
            b_d = old_d; b_p = old_p;
         end
         pend_vld  = re;
         pend_dat  = b_d;
         pend_perr = re && ((^b_d) != b_p);
         ea_vld  = re;
         if (re) ea_dout = old_d;
         ea_perr = re && ((^old_d) != old_p);
         if (we) begin
            m_mem[wa] = din;
            m_par[wa] = (^din) ^ err;
         end
      end
      e_busy = (clear_left > 0);
   endtask

   // Advance one clock: model follows the edge, outputs are then sampled at negedge.
   task automatic tick();
      @(posedge clk);
      if (rst) model_step();
      @(negedge clk);
   endtask

   task automatic wait_clear(output int cycles);
      cycles = 0;
      while (if_a.init_busy === 1'b1 && cycles < 40) begin
         tick();
         cycles++;
      end
   endtask

   task automatic test_reset();
      int cyc;
      @(negedge clk);
      we = 0; re = 0; rst = 1'b0;
      model_reset();
      #1;
      n_run++;
      if ({if_a.dout, if_a.rd_valid, if_a.init_busy} !== {8'h00, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_a got %h/%b/%b exp 00/0/1", if_a.dout, if_a.rd_valid, if_a.init_busy);
      end
      n_run++;
      if ({if_b.dout, if_b.rd_valid, if_b.init_busy} !== {8'h00, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_b got %h/%b/%b exp 00/0/1", if_b.dout, if_b.rd_valid, if_b.init_busy);
      end
      @(negedge clk);
      tick();
      rst = 1'b1;
      wait_clear(cyc);
      n_run++;
      if (cyc !== 16) begin
         n_fail++;
         $display("FAIL clear_len got %0d exp 16", cyc);
      end
      n_run++;
      if (if_b.init_busy !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_done_b got %b exp 0", if_b.init_busy);
      end
      re = 1; ra = 4'd5;
      tick();
      re = 0;
      n_run++;
      if ({if_a.dout, if_a.rd_valid} !== {8'h00, 1'b1}) begin
         n_fail++;
         $display("FAIL reset_read5 got %h/%b exp 00/1", if_a.dout, if_a.rd_valid);
      end
   endtask

   task automatic test_write_read();
      for (int i = 0; i < 7; i++) begin
         we = 1; wa = 4'(i); din = 8'(i + 1);
         tick();
      end
      we = 0;
      for (int i = 0; i < 7; i++) begin
         re = 1; ra = 4'(i);
         tick();
         n_run++;
         if ({if_a.dout, if_a.rd_valid} !== {8'(i + 1), 1'b1}) begin
            n_fail++;
            $display("FAIL wr_rd_%0d got %h/%b exp %h/1", i, if_a.dout, if_a.rd_valid, 8'(i + 1));
         end
      end
      re = 0;
      tick();
      n_run++;
      if ({if_a.dout, if_a.rd_valid} !== {8'h07, 1'b0}) begin
         n_fail++;
         $display("FAIL wr_rd_hold got %h/%b exp 07/0", if_a.dout, if_a.rd_valid);
      end
   endtask

   task automatic test_collision();
      we = 1; wa = 4'd3; din = 8'h04;
      tick();
      din = 8'hAA; re = 1; ra = 4'd3;
      tick();
      we = 0;
      n_run++;
      if ({if_a.dout, if_a.rd_valid} !== {8'h04, 1'b1}) begin
         n_fail++;
         $display("FAIL coll_read_first got %h/%b exp 04/1", if_a.dout, if_a.rd_valid);
      end
      tick();
      re = 0;
      n_run++;
      if ({if_b.dout, if_b.rd_valid} !== {8'hAA, 1'b1}) begin
         n_fail++;
         $display("FAIL coll_write_first got %h/%b exp AA/1", if_b.dout, if_b.rd_valid);
      end
      n_run++;
      if ({if_a.dout, if_a.rd_valid} !== {8'hAA, 1'b1}) begin
         n_fail++;
         $display("FAIL coll_after got %h/%b exp AA/1", if_a.dout, if_a.rd_valid);
      end
      tick();
   endtask

   task automatic test_ignore_clear();
      int cyc;
      rst = 1'b0;
      model_reset();
      tick();
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         we = 1; wa = 4'd2; din = 8'h55; re = 1; ra = 4'd2;
         tick();
         n_run++;
         if ({if_a.rd_valid, if_b.rd_valid, if_a.init_busy} !== 3'b001) begin
            n_fail++;
            $display("FAIL clear_ignore_%0d got va=%b vb=%b busy=%b exp 0 0 1", i, if_a.rd_valid, if_b.rd_valid, if_a.init_busy);
         end
      end
      we = 0; re = 0;
      wait_clear(cyc);
      re = 1; ra = 4'd2;
      tick();
      re = 0;
      n_run++;
      if ({if_a.dout, if_a.rd_valid} !== {8'h00, 1'b1}) begin
         n_fail++;
         $display("FAIL clear_read2 got %h/%b exp 00/1", if_a.dout, if_a.rd_valid);
      end
      tick();
   endtask

   task automatic test_out_reg();
      we = 1; wa = 4'd1; din = 8'h02;
      tick();
      we = 0; re = 1; ra = 4'd1;
      tick();
      re = 0;
      n_run++;
      if (if_b.rd_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL outreg_early got vld=%b exp 0", if_b.rd_valid);
      end
      tick();
      n_run++;
      if ({if_b.dout, if_b.rd_valid} !== {8'h02, 1'b1}) begin
         n_fail++;
         $display("FAIL outreg_lat2 got %h/%b exp 02/1", if_b.dout, if_b.rd_valid);
      end
      for (int i = 0; i < 4; i++) begin
         we = 1; wa = 4'(8 + i); din = 8'(8'h10 + i);
         tick();
      end
      we = 0;
      for (int i = 0; i < 6; i++) begin
         re = (i < 4); ra = 4'(8 + i);
         tick();
         if (i >= 1 && i <= 4) begin
            n_run++;
            if ({if_b.dout, if_b.rd_valid} !== {8'(8'h10 + i - 1), 1'b1}) begin
               n_fail++;
               $display("FAIL outreg_burst_%0d got %h/%b exp %h/1", i, if_b.dout, if_b.rd_valid, 8'(8'h10 + i - 1));
            end
         end
      end
      re = 0;
   endtask

   task automatic test_random();
      for (int c = 0; c < 300; c++) begin
         we  = 1'($urandom);
         re  = 1'($urandom);
         wa  = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
         ra  = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
         din = 8'($urandom);
`ifdef SYNC_DPRAM_PARITY_EN
         err = ($urandom_range(0, 7) == 0);
`endif
         tick();
         n_run++;
         if ({if_a.dout, if_a.rd_valid, if_a.init_busy} !== {ea_dout, ea_vld, e_busy}) begin
            n_fail++;
            $display("FAIL rand_a cyc%0d got %h/%b/%b exp %h/%b/%b", c, if_a.dout, if_a.rd_valid, if_a.init_busy, ea_dout, ea_vld, e_busy);
         end
         n_run++;
         if ({if_b.dout, if_b.rd_valid, if_b.init_busy} !== {eb_dout, eb_vld, e_busy}) begin
            n_fail++;
            $display("FAIL rand_b cyc%0d got %h/%b/%b exp %h/%b/%b", c, if_b.dout, if_b.rd_valid, if_b.init_busy, eb_dout, eb_vld, e_busy);
         end
`ifdef SYNC_DPRAM_PARITY_EN
         n_run++;
         if ({if_a.rd_perr, if_b.rd_perr} !== {ea_perr, eb_perr}) begin
            n_fail++;
            $display("FAIL rand_perr cyc%0d got %b%b exp %b%b", c, if_a.rd_perr, if_b.rd_perr, ea_perr, eb_perr);
         end
`endif
      end
      we = 0; re = 0; err = 0;
   endtask

   task automatic test_mid_reset();
      int cyc;
      for (int i = 0; i < DEPTH; i++) begin
         we = 1; wa = 4'(i); din = 8'(8'h80 | i);
         tick();
      end
      we = 0;
      for (int i = 0; i < 3; i++) begin
         re = 1; ra = 4'(i + 4);
         tick();
      end
      rst = 1'b0;
      model_reset();
      #1;
      n_run++;
      if ({if_a.dout, if_a.rd_valid, if_a.init_busy} !== {8'h00, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL midrst_a got %h/%b/%b exp 00/0/1", if_a.dout, if_a.rd_valid, if_a.init_busy);
      end
      n_run++;
      if ({if_b.dout, if_b.rd_valid, if_b.init_busy} !== {8'h00, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL midrst_b got %h/%b/%b exp 00/0/1", if_b.dout, if_b.rd_valid, if_b.init_busy);
      end
      re = 0;
      @(negedge clk);
      tick();
      rst = 1'b1;
      wait_clear(cyc);
      n_run++;
      if (cyc !== 16) begin
         n_fail++;
         $display("FAIL midrst_clear_len got %0d exp 16", cyc);
      end
      for (int i = 0; i < DEPTH; i++) begin
         re = 1; ra = 4'(i);
         tick();
         n_run++;
         if ({if_a.dout, if_a.rd_valid} !== {8'h00, 1'b1}) begin
            n_fail++;
            $display("FAIL midrst_zero_%0d got %h/%b exp 00/1", i, if_a.dout, if_a.rd_valid);
         end
      end
      re = 0;
      tick();
   endtask

`ifdef SYNC_DPRAM_PARITY_EN
   task automatic test_parity();
      we = 1; wa = 4'd4; din = 8'h0F; err = 1;
      tick();
      wa = 4'd6; din = 8'h0F; err = 0;
      tick();
      we = 0; re = 1; ra = 4'd4;
      tick();
      n_run++;
      if ({if_a.rd_valid, if_a.rd_perr} !== 2'b11) begin
         n_fail++;
         $display("FAIL perr_inject got vld=%b perr=%b exp 1 1", if_a.rd_valid, if_a.rd_perr);
      end
      ra = 4'd6;
      tick();
      re = 0;
      n_run++;
      if ({if_a.rd_valid, if_a.rd_perr} !== 2'b10) begin
         n_fail++;
         $display("FAIL perr_clean got vld=%b perr=%b exp 1 0", if_a.rd_valid, if_a.rd_perr);
      end
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_write_read();
      test_collision();
      test_ignore_clear();
      test_out_reg();
      test_random();
      test_mid_reset();
`ifdef SYNC_DPRAM_PARITY_EN
      test_parity();
`endif
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL timeout simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
